// File: rtl/pipeline_pkg.sv
// Shared helpers for the pipeline stages.
//   count_bits(n) : width needed to hold the values 0..n inclusive.
package pipeline_pkg;

  function automatic int count_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipeline_obuf.sv
// Single-entry registered output buffer with valid/ready.
// Handshake: a word transfers on any rising edge where valid_o & ready_i.
// ready_o = ~valid_o | ready_i, so a new word may be loaded in the same
// cycle the current one drains (no bubble).
//   clock, reset_n : clock, synchronous active-low reset
//   load_i, data_i : capture data_i and raise valid (caller only loads when ready_o)
//   ready_i        : downstream accepts the held word
//   data_o, valid_o: held word and its valid flag
//   ready_o        : buffer can take a new word this cycle
module pipeline_obuf #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         ready_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      // Load wins over drain: the new word replaces the departing one.
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      // Data is kept; only the valid flag drops.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ready_o = ~valid_q | ready_i;

endmodule

// File: rtl/pipeline_pack.sv
// Width-converting packer: gathers RATIO accepted VALUE_BITS beats (or fewer
// when i_last closes a word early) into one RATIO*VALUE_BITS word, lane 0 in
// the low bits, and presents it through a registered valid/ready output.
// Handshake on both sides: a transfer happens on a rising edge where
// valid & ready are both high; ready never depends on valid.
//   clock, reset_n          : clock, synchronous active-low reset
//   i_value, i_last, i_valid: input beat, end-of-stream flag, beat valid
//   o_ready                 : input beat accepted this cycle if i_valid
//   o_value, o_count, o_last: packed word, filled lanes (1..RATIO), closed by i_last
//   o_valid, i_ready        : output word valid, downstream ready
module pipeline_pack
  import pipeline_pkg::*;
#(
  parameter  int VALUE_BITS = 8,
  parameter  int RATIO      = 4,
  localparam int COUNT_BITS = count_bits(RATIO)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [VALUE_BITS-1:0]       i_value,
  input  logic                        i_last,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [RATIO*VALUE_BITS-1:0] o_value,
  output logic [COUNT_BITS-1:0]       o_count,
  output logic                        o_last,
  output logic                        o_valid,
  input  logic                        i_ready
);

  localparam int WORD_BITS = RATIO * VALUE_BITS;
  localparam int OBUF_W    = WORD_BITS + COUNT_BITS + 1;

  logic [COUNT_BITS-1:0] fill_q, fill_d;
  logic [WORD_BITS-1:0]  acc_q, acc_d;
  logic [WORD_BITS-1:0]  merged;
  logic                  accept;
  logic                  close;
  logic                  load;
  logic [OBUF_W-1:0]     obuf_din;
  logic [OBUF_W-1:0]     obuf_dout;

  assign accept = i_valid & o_ready;
  assign close  = (fill_q == COUNT_BITS'(RATIO - 1)) | i_last;
  assign load   = accept & close;

  // Accumulator with the current beat dropped into lane fill_q. Lanes above
  // fill_q are zero because the accumulator is cleared after every close.
  always_comb begin
    merged = acc_q;
    for (int l = 0; l < RATIO; l++) begin
      if (fill_q == COUNT_BITS'(l)) begin
        merged[l*VALUE_BITS +: VALUE_BITS] = i_value;
      end
    end
  end

  always_comb begin
    fill_d = fill_q;
    acc_d  = acc_q;
    if (accept) begin
      if (close) begin
        fill_d = '0;
        acc_d  = '0;
      end else begin
        fill_d = fill_q + COUNT_BITS'(1);
        acc_d  = merged;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fill_q <= '0;
      acc_q  <= '0;
    end else begin
      fill_q <= fill_d;
      acc_q  <= acc_d;
    end
  end

  assign obuf_din = {i_last, fill_q + COUNT_BITS'(1), merged};

  pipeline_obuf #(
    .W(OBUF_W)
  ) u_obuf (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (load),
    .data_i  (obuf_din),
    .ready_i (i_ready),
    .data_o  (obuf_dout),
    .valid_o (o_valid),
    .ready_o (o_ready)
  );

  assign o_value = obuf_dout[WORD_BITS-1:0];
  assign o_count = obuf_dout[WORD_BITS +: COUNT_BITS];
  assign o_last  = obuf_dout[OBUF_W-1];

endmodule

// File: tb/tb_pipeline_pack.sv
// Bench for pipeline_pack: a RATIO=4 instance and a RATIO=1 instance share
// the same input stream and downstream ready. A beat-level model per instance
// (byte count + shifted accumulation) predicts every output every cycle.
module tb_pipeline_pack;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  i_value;
  logic        i_last;
  logic        i_valid;
  logic        i_ready;

  logic        o_ready0, o_last0, o_valid0;
  logic [31:0] o_value0;
  logic [2:0]  o_count0;
  logic        o_ready1, o_last1, o_valid1;
  logic [7:0]  o_value1;
  logic [0:0]  o_count1;

  pipeline_pack #(.VALUE_BITS(8), .RATIO(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .i_value(i_value), .i_last(i_last),
    .i_valid(i_valid), .o_ready(o_ready0), .o_value(o_value0),
    .o_count(o_count0), .o_last(o_last0), .o_valid(o_valid0), .i_ready(i_ready)
  );

  pipeline_pack #(.VALUE_BITS(8), .RATIO(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .i_value(i_value), .i_last(i_last),
    .i_valid(i_valid), .o_ready(o_ready1), .o_value(o_value1),
    .o_count(o_count1), .o_last(o_last1), .o_valid(o_valid1), .i_ready(i_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  bit rnd_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          ratio_of [2] = '{4, 1};
  int          m_n      [2] = '{0, 0};
  logic [31:0] m_acc    [2] = '{0, 0};
  logic [31:0] m_val    [2] = '{0, 0};
  int          m_cnt    [2] = '{0, 0};
  logic        m_last   [2] = '{0, 0};
  logic        m_valid  [2] = '{0, 0};
  logic [31:0] exp_q[$];

  always @(negedge clock) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [31:0] ov;
        logic [31:0] oc;
        logic        ol, ovl, ord;
        logic        acc, drain, cls;
        ov  = (k == 0) ? o_value0 : {24'h0, o_value1};
        oc  = (k == 0) ? {29'h0, o_count0} : {31'h0, o_count1};
        ol  = (k == 0) ? o_last0 : o_last1;
        ovl = (k == 0) ? o_valid0 : o_valid1;
        ord = (k == 0) ? o_ready0 : o_ready1;
        check($sformatf("r%0d_valid", ratio_of[k]), {31'h0, ovl}, {31'h0, m_valid[k]});
        check($sformatf("r%0d_ready", ratio_of[k]), {31'h0, ord}, {31'h0, ~m_valid[k] | i_ready});
        check($sformatf("r%0d_value", ratio_of[k]), ov, m_val[k]);
        check($sformatf("r%0d_count", ratio_of[k]), oc, 32'(m_cnt[k]));
        check($sformatf("r%0d_last", ratio_of[k]), {31'h0, ol}, {31'h0, m_last[k]});

        // Advance model to the state after the coming rising edge.
        if (!reset_n) begin
          m_n[k] = 0; m_acc[k] = 0; m_val[k] = 0; m_cnt[k] = 0;
          m_last[k] = 0; m_valid[k] = 0;
          if (k == 0) exp_q.delete();
        end else begin
          acc   = i_valid & (~m_valid[k] | i_ready);
          drain = m_valid[k] & i_ready;
          cls   = 1'b0;
          if (k == 0 && drain) begin
            if (exp_q.size() == 0) check("drain_unexpected", ov, 32'h0 - 1);
            else check("drain_word", ov, exp_q.pop_front());
          end
          if (acc) begin
            m_acc[k] = m_acc[k] | (32'(i_value) << (8 * m_n[k]));
            m_n[k]++;
            if (m_n[k] == ratio_of[k] || i_last) begin
              cls = 1'b1;
              m_val[k] = m_acc[k]; m_cnt[k] = m_n[k]; m_last[k] = i_last;
              m_valid[k] = 1'b1;
              if (k == 0) exp_q.push_back(m_acc[k]);
              m_acc[k] = 0; m_n[k] = 0;
            end
          end
          if (!cls && drain) m_valid[k] = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one beat until the RATIO=4 instance accepts it.
  task automatic send(input logic [7:0] v, input logic l);
    bit done = 1'b0;
    int t = 0;
    i_valid = 1'b1; i_value = v; i_last = l;
    while (!done) begin
      @(negedge clock);
      done = o_ready0;
      @(posedge clock); #1;
      t++;
      if (!done && t > 100) begin
        check("send_timeout", 32'(t), 32'd100);
        done = 1'b1;
      end
    end
    i_valid = 1'b0; i_value = $urandom_range(0, 255); i_last = $urandom_range(0, 1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; i_value = 8'h0; i_last = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clock); #1;
    mon_en = 1'b1;
    check("reset_value", o_value0, 32'h0);
    check("reset_valid", {31'h0, o_valid0}, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(2);

    // Full word, then a short word closed by i_last.
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    check("t1_value", o_value0, 32'h44332211);
    check("t1_count", {29'h0, o_count0}, 32'd4);
    check("t1_valid", {31'h0, o_valid0}, 32'd1);
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    check("t2_value", o_value0, 32'h0000BBAA);
    check("t2_count", {29'h0, o_count0}, 32'd2);
    check("t2_last", {31'h0, o_last0}, 32'd1);
    idle(2);

    // Stall with upstream still offering a beat.
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    i_ready = 1'b0;
    send(8'h04, 1'b0);
    fork
      send(8'h05, 1'b0);
      begin
        repeat (5) begin
          @(negedge clock);
          check("t3_stall_ready", {31'h0, o_ready0}, 32'd0);
          check("t3_stall_value", o_value0, 32'h04030201);
        end
        @(posedge clock); #1;
        i_ready = 1'b1;
      end
    join
    send(8'h06, 1'b0); send(8'h07, 1'b0); send(8'h08, 1'b0);
    check("t3_resume", o_value0, 32'h08070605);
    idle(2);

    // Sixteen back-to-back beats.
    for (int b = 0; b < 16; b++) send(8'(b), 1'b0);
    check("t4_last_word", o_value0, 32'h0F0E0D0C);
    idle(2);

    // Reset in the middle of a word.
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    reset_n = 1'b0;
    idle(1);
    check("t5_reset_value", o_value0, 32'h0);
    check("t5_reset_count", {29'h0, o_count0}, 32'd0);
    reset_n = 1'b1;
    send(8'h5A, 1'b0); send(8'h5B, 1'b0); send(8'h5C, 1'b0); send(8'h5D, 1'b0);
    check("t5_value", o_value0, 32'h5D5C5B5A);
    idle(2);

    // RATIO=1 instance: each beat is its own word.
    send(8'h7E, 1'b0);
    check("t6_first", {24'h0, o_value1}, 32'h7E);
    check("t6_first_count", {31'h0, o_count1}, 32'd1);
    send(8'h7F, 1'b0);
    check("t6_second", {24'h0, o_value1}, 32'h7F);
    check("t6_second_valid", {31'h0, o_valid1}, 32'd1);
    send(8'h01, 1'b1);
    idle(2);

    // Random traffic with random downstream back-pressure.
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #1;
          i_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    i_ready = 1'b1;
    idle(4);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
